// File: rtl/hapara_lmb_dma_bram_wr.sv
// hapara_lmb_dma_bram_wr
// Command-driven stream-to-BRAM write engine feeding the LMB DMA duplicator's
// controller port. A command (byte base address, word count) is accepted, then
// that many AXI-Stream beats are written with full byte enables, one write per
// accepted beat, registered one cycle after the handshake.
// Optional feature macro: HAPARA_DMA_WR_TLAST_CHK_EN adds the sticky err output
// that flags tlast misplacement relative to the commanded word count.
module hapara_lmb_dma_bram_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   addr_ctrl,
  output logic [DATA_WIDTH-1:0]   data_in_ctrl,
  input  logic [DATA_WIDTH-1:0]   data_out_ctrl,
  output logic [DATA_WIDTH/8-1:0] we_ctrl,
  output logic                    en_ctrl,
  output logic                    clk_ctrl,
  output logic                    rst_ctrl
`ifdef HAPARA_DMA_WR_TLAST_CHK_EN
  ,
  output logic                    err
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_cmd_ready;
  logic                    r_busy;
  logic                    r_done;
  logic [ADDR_WIDTH-1:0]   r_addr_ctrl;
  logic [DATA_WIDTH-1:0]   r_data_in_ctrl;
  logic [BYTES-1:0]        r_we_ctrl;
  logic                    r_en_ctrl;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [LEN_WIDTH-1:0]    r_cnt;

  logic                    w_cmd_acc;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_unused;

  assign w_cmd_acc = cmd_valid & r_cmd_ready;
  assign w_beat    = s_axis_tvalid & (r_state == ST_XFER);
  assign w_last    = (r_cnt == LEN_WIDTH'(1));

`ifdef HAPARA_DMA_WR_TLAST_CHK_EN
  logic r_err;
  logic w_early;
  logic w_missing;

  // tlast before the final word ends the transfer early; no tlast on the final word is flagged only
  assign w_early   = w_beat & s_axis_tlast & ~w_last;
  assign w_missing = w_beat & ~s_axis_tlast & w_last;
  assign err       = r_err;
  // Read data is never used by a write-only engine
  assign w_unused  = ^data_out_ctrl;
`else
  // Read data and tlast carry no meaning when only the word count ends a transfer
  assign w_unused  = ^{data_out_ctrl, s_axis_tlast};
`endif

  assign cmd_ready     = r_cmd_ready;
  assign s_axis_tready = (r_state == ST_XFER);
  assign busy          = r_busy;
  assign done          = r_done;
  assign addr_ctrl     = r_addr_ctrl;
  assign data_in_ctrl  = r_data_in_ctrl;
  assign we_ctrl       = r_we_ctrl;
  assign en_ctrl       = r_en_ctrl;
  assign clk_ctrl      = clk;
  assign rst_ctrl      = rst;

  // Transfer FSM with registered handshake, status and BRAM write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cmd_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_addr_ctrl    <= {ADDR_WIDTH{1'b0}};
      r_data_in_ctrl <= {DATA_WIDTH{1'b0}};
      r_we_ctrl      <= {BYTES{1'b0}};
      r_en_ctrl      <= 1'b0;
      r_cur_addr     <= {ADDR_WIDTH{1'b0}};
      r_cnt          <= {LEN_WIDTH{1'b0}};
`ifdef HAPARA_DMA_WR_TLAST_CHK_EN
      r_err          <= 1'b0;
`endif
    end else begin
      // A write only exists in the cycle right after an accepted beat
      r_en_ctrl <= 1'b0;
      r_we_ctrl <= {BYTES{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_cur_addr  <= cmd_addr;
            r_cnt       <= cmd_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef HAPARA_DMA_WR_TLAST_CHK_EN
            r_err       <= 1'b0;
`endif
            if (cmd_len == {LEN_WIDTH{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_XFER;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_beat) begin
            r_en_ctrl      <= 1'b1;
            r_we_ctrl      <= {BYTES{1'b1}};
            r_addr_ctrl    <= r_cur_addr;
            r_data_in_ctrl <= s_axis_tdata;
            r_cur_addr     <= r_cur_addr + ADDR_WIDTH'(BYTES);
            r_cnt          <= r_cnt - LEN_WIDTH'(1);
`ifdef HAPARA_DMA_WR_TLAST_CHK_EN
            if (w_early || w_missing) begin
              r_err <= 1'b1;
            end else begin
              r_err <= r_err;
            end
            if (w_last || w_early) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_XFER;
            end
`else
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_XFER;
            end
`endif
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
